// File: rtl/enc8_3_arb.sv
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ready output handshake. Pending bits are set by requests and cleared
// when the consumer accepts the code that names them.
module enc8_3_arb #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] in,
  input  logic       ready,
  output logic [2:0] y,
  output logic       valid,
  output logic [7:0] pend,
  output logic       lost
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] y_nxt;
  logic [7:0] cap;
  logic       acc;
  logic [7:0] clr;
  logic [7:0] sel;

  // Index of the winning bit; when nothing is set the result is unused.
  function automatic logic [2:0] prio(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  assign valid = (state == FULL);

  // Capture mask, acceptance clear and the set the encoder may pick from;
  // bits captured this cycle only become selectable on the next one.
  always_comb begin
    cap = en ? in : 8'h00;
    acc = valid & ready;
    clr = acc ? (8'b1 << y) : 8'h00;
    sel = pend & ~clr;
  end

  // Output slot control: load a new code when empty or when the current one
  // is taken; hold steady under backpressure even if a better request shows up.
  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    case (state)
      EMPTY: begin
        if (|sel) begin
          y_nxt     = prio(sel);
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (ready) begin
          if (|sel) begin
            y_nxt = prio(sel);
          end else begin
            state_nxt = EMPTY;
          end
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  // Registers for pending bits, overflow pulse and the presented code;
  // a new capture on the same bit as an accept keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend  <= 8'h00;
      lost  <= 1'b0;
      y     <= 3'd0;
      state <= EMPTY;
    end else begin
      pend  <= sel | cap;
      lost  <= |(cap & sel);
      y     <= y_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_enc8_3_arb.sv
// Directed bench for enc8_3_arb: one instance per priority order, both driven
// by the same stimulus, every expected value worked out by hand.
module tb_enc8_3_arb;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] in;
  logic       ready;

  logic [2:0] y_l, y_m;
  logic       valid_l, valid_m;
  logic [7:0] pend_l, pend_m;
  logic       lost_l, lost_m;

  int compared   = 0;
  int mismatched = 0;

  enc8_3_arb #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .ready(ready),
    .y(y_l), .valid(valid_l), .pend(pend_l), .lost(lost_l)
  );

  enc8_3_arb #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .in(in), .ready(ready),
    .y(y_m), .valid(valid_m), .pend(pend_m), .lost(lost_m)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs just after an edge, then step one clock and settle.
  task automatic applyStimulus(input logic e, input logic [7:0] v, input logic r);
    en    = e;
    in    = v;
    ready = r;
    @(posedge clk);
    #1;
  endtask

  // Shared check of the LSB-first instance's full output set.
  task automatic checkLsb(input string tag, input logic [7:0] p, input logic v,
                          input logic [2:0] yy, input logic l);
    checkOutput({tag, "_pend"}, pend_l, p);
    checkOutput({tag, "_valid"}, {7'd0, valid_l}, {7'd0, v});
    if (v) checkOutput({tag, "_y"}, {5'd0, y_l}, {5'd0, yy});
    checkOutput({tag, "_lost"}, {7'd0, lost_l}, {7'd0, l});
  endtask

  logic [2:0] drain_l [4];
  logic [2:0] drain_m [4];

  initial begin
    drain_l = '{3'd0, 3'd2, 3'd5, 3'd7};
    drain_m = '{3'd7, 3'd5, 3'd2, 3'd0};
    rst_n = 1'b0;
    en    = 1'b0;
    in    = 8'h00;
    ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkLsb("por", 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("por_y", {5'd0, y_l}, 8'h00);
    #2 rst_n = 1'b1;

    // Build up state, then reset asynchronously in the middle of a cycle.
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkLsb("fill", 8'hFF, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkLsb("fill2", 8'hFF, 1'b1, 3'd0, 1'b1);
    checkOutput("fill2_msb_y", {5'd0, y_m}, 8'd7);
    #3 rst_n = 1'b0;
    #1;
    checkLsb("arst", 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("arst_y", {5'd0, y_l}, 8'h00);
    checkOutput("arst_msb_pend", pend_m, 8'h00);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkLsb("idle1", 8'h00, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkLsb("idle2", 8'h00, 1'b0, 3'd0, 1'b0);

    // Single request travels through in two edges and is taken at once.
    applyStimulus(1'b1, 8'h20, 1'b1);
    checkLsb("single_cap", 8'h20, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("single_pres", 8'h20, 1'b1, 3'd5, 1'b0);
    checkOutput("single_msb_y", {5'd0, y_m}, 8'd5);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("single_done", 8'h00, 1'b0, 3'd0, 1'b0);

    // Back-to-back drain in both priority orders.
    applyStimulus(1'b1, 8'hA5, 1'b1);
    checkLsb("drain_cap", 8'hA5, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'h00, 1'b1);
      checkOutput($sformatf("drain_l%0d_valid", i), {7'd0, valid_l}, 8'd1);
      checkOutput($sformatf("drain_l%0d_y", i), {5'd0, y_l}, {5'd0, drain_l[i]});
      checkOutput($sformatf("drain_m%0d_valid", i), {7'd0, valid_m}, 8'd1);
      checkOutput($sformatf("drain_m%0d_y", i), {5'd0, y_m}, {5'd0, drain_m[i]});
    end
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("drain_end", 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("drain_end_msb_valid", {7'd0, valid_m}, 8'd0);

    // Backpressure: code 4 holds while a higher-priority bit 0 arrives.
    applyStimulus(1'b1, 8'h10, 1'b0);
    checkLsb("bp_cap", 8'h10, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b0);
    checkLsb("bp_pres", 8'h11, 1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkLsb("bp_hold", 8'h11, 1'b1, 3'd4, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("bp_next", 8'h01, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("bp_done", 8'h00, 1'b0, 3'd0, 1'b0);

    // Set wins over clear, then a repeat capture while held flags lost.
    applyStimulus(1'b1, 8'h08, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("sc_pres", 8'h08, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b1);
    checkLsb("sc_same", 8'h08, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkLsb("sc_again", 8'h08, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h08, 1'b0);
    checkLsb("lost_hit", 8'h08, 1'b1, 3'd3, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b0);
    checkLsb("lost_end", 8'h08, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1);
    checkLsb("sc_done", 8'h00, 1'b0, 3'd0, 1'b0);

    // Enable gating: requests ignored, existing bits still drain.
    applyStimulus(1'b1, 8'h42, 1'b0);
    checkLsb("en_cap", 8'h42, 1'b0, 3'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'hFF, 1'b0);
      checkLsb($sformatf("en_gate%0d", i), 8'h42, 1'b1, 3'd1, 1'b0);
      checkOutput($sformatf("en_gate%0d_msb_y", i), {5'd0, y_m}, 8'd6);
    end
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkLsb("en_drain1", 8'h40, 1'b1, 3'd6, 1'b0);
    checkOutput("en_drain1_msb_y", {5'd0, y_m}, 8'd1);
    checkOutput("en_drain1_msb_pend", pend_m, 8'h02);
    applyStimulus(1'b0, 8'hFF, 1'b1);
    checkLsb("en_drain2", 8'h00, 1'b0, 3'd0, 1'b0);
    checkOutput("en_drain2_msb_valid", {7'd0, valid_m}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
